step_sequencer: RTL
===================

# step_sequencer

Pattern step sequencer that sits directly downstream of the `tempo` divider. It consumes one tempo note-value square wave (typically `sixteenth` or `eighth`) and advances through a programmable pattern RAM of notes. On each step it emits a note number, a timed gate and a one-cycle trigger for the voice/envelope stages. It runs entirely in the `OSC` domain (49.152 MHz).

## Interface

Parameters:
- `STEPS`, 16: pattern depth. Power of two, 2–64. `SB = $clog2(STEPS)`.
- `NOTE_BITS`, 7: note number width (MIDI range).
- `GATE_BITS`, 24: width of the gate-length and delay counters, in `OSC` cycles.

Ports:
- `OSC`, in, 1: system clock.
- `RESET`, in, 1: asynchronous, active-low reset.
- `tick_in`, in, 1: tempo square wave. Treated as asynchronous. Each rising edge requests one step.
- `run`, in, 1: level. Low holds the sequencer idle.
- `length`, in, SB: last step index of the pattern. The pattern length is `length+1`.
- `gate_len`, in, GATE_BITS: gate high time in `OSC` cycles.
- `wr_en`, in, 1: pattern RAM write strobe.
- `wr_addr`, in, SB: RAM write address.
- `wr_note`, in, NOTE_BITS: note number to write.
- `wr_active`, in, 1: 0 marks the step as a rest.
- `step`, out, SB: index of the current step.
- `note`, out, NOTE_BITS: note latched at step start.
- `gate`, out, 1: note gate.
- `trigger`, out, 1: one-cycle pulse at the start of each active step.
- `wrap`, out, 1: one-cycle pulse when the step index returns to 0.

## Operation

Input conditioning:
- `tick_in` passes through a 2-flop synchronizer, then a rising-edge detector. The detector output is `tick_p`.

Pattern RAM:
- `STEPS` x (`NOTE_BITS`+1) entries.
- Synchronous write. Readable in the same cycle as `tick_p`.
- Reset does not clear the RAM contents.

FSM states: IDLE, WAIT, GATE, GAP.
- IDLE: `step`=0, `gate`=0. Goes to WAIT when `run`=1. The first `tick_p` after entering WAIT plays step 0.
- WAIT, on `tick_p`, for step `s`:
  - latch `note`=RAM[`s`].note;
  - if the entry is active and `gate_len`≠0: pulse `trigger`, set `gate`=1, load the gate counter with `gate_len`, go to GATE;
  - otherwise (rest, or `gate_len`=0): stay in WAIT with `gate`=0, and suppress `trigger`.
- GATE: decrement the counter each cycle. When it reaches 0: `gate`=0, go to WAIT.
- Step index update on each `tick_p`:
  - `s` advances to `s`+1;
  - if `s` ≥ `length`, it wraps to 0 and `wrap` pulses.
- GAP: entered from GATE when `tick_p` arrives before the counter expires. Forces `gate`=0 for exactly one cycle. The pending step is then processed as in WAIT, so back-to-back gates always have a 1-cycle low gap (retrigger).
- `run` falling edge, from any state: go to IDLE on the next edge. `gate`=0, `step`=0, no `wrap` pulse.

Boundary rules:
- `length` lowered below the current `step`: the next `tick_p` wraps to 0.
- Write to the step currently playing: no effect on `note` until the next visit to that step.
- `gate_len` ≥ tick period: gate stays high until the next tick, then the GAP retrigger applies.
- `tick_p` in the same cycle as `run` falls: `run` wins, and the step is not played.

## Timing

- Reset values: `step`=0, `note`=0, `gate`=0, `trigger`=0, `wrap`=0, FSM=IDLE, synchronizer flops=0.
- Latency from tick to step:
  - `tick_in` is first sampled high at edge N;
  - `trigger`, `gate` rise, `note` and `step` become valid after edge N+3.
- `trigger` and `wrap` are high for exactly one `OSC` cycle.
- Gate width is exactly `gate_len` cycles, unless cut short by GAP.
- A GAP retrigger delays the new step's outputs by 1 cycle, relative to the N+3 rule.
- Writes: the RAM updates at the edge where `wr_en`=1. A `tick_p` in the same cycle to the same address reads the old data.
- `run` low at edge N: `gate`=0 and `step`=0 after edge N+1.
- Asserting `RESET` mid-gate drops `gate` immediately (asynchronous). Release is sampled at the next `OSC` edge.

## Configuration

- `STEP_SEQUENCER_SWING_EN` defined:
  - adds input `swing_delay` [GATE_BITS-1:0] and an extra FSM state DELAY;
  - on `tick_p` for an odd step, the FSM waits `swing_delay` cycles in DELAY before the WAIT processing, so all outputs shift by `swing_delay`;
  - `swing_delay`=0 behaves as if the macro were undefined;
  - a `tick_p` during DELAY ends the delay immediately, the delayed step plays, and the new tick is processed next cycle.
- Undefined: no `swing_delay` port and no DELAY state. All steps follow the N+3 rule.

## Test plan

- Reset/idle: hold `RESET`=0 with `run`=1 and toggle `tick_in` → all outputs stay 0. Release with `run`=0 and keep ticking → `step`=0, `gate`=0 throughout.
- Basic play: RAM = {60, 62, 64, 65}, `length`=3, `gate_len`=100, `run`=1, four ticks →
  - `note` sequence 60, 62, 64, 65;
  - `trigger` 1 cycle at N+3 of each tick;
  - `gate` 100 cycles wide;
  - `wrap` pulses on the 5th tick.
- Retrigger: `gate_len`=0xFFFFFF, ticks every 1000 cycles → `gate` low for exactly 1 cycle before each new step. Step 1 rest (`wr_active`=0) → no trigger and gate stays low for that step.
- Boundaries: `length` changed 7→2 while `step`=5 → the next tick gives `step`=0 with a `wrap` pulse. Same-cycle write to the addressed step → the old note plays. `run` falls together with `tick_p` → no trigger, `step`=0.
- Swing (`STEP_SEQUENCER_SWING_EN`): `swing_delay`=50 → odd-step triggers land at N+53 and even-step triggers at N+3. A tick during DELAY plays the delayed step, then the next step one cycle later.

Source files
------------

// File: rtl/step_sequencer.sv
// -----------------------------------------------------------------------------
// step_sequencer
//
// Pattern step sequencer clocked by OSC. A tempo square wave (tick_in) is
// synchronized and edge-detected; each rising edge advances through a
// programmable pattern RAM and produces a note number, a timed gate and a
// one-cycle trigger for the downstream voice/envelope stages.
//
// Optional feature macro: STEP_SEQUENCER_SWING_EN
//   Adds the swing_delay input and a DELAY state that postpones odd steps by
//   swing_delay OSC cycles. Undefined by default.
//
// Ports:
//   OSC          system clock
//   RESET        asynchronous active-low reset
//   tick_in      tempo square wave (asynchronous), rising edge = one step
//   run          level; low forces the sequencer idle
//   length       last step index of the pattern (pattern length = length+1)
//   gate_len     gate high time in OSC cycles
//   swing_delay  odd-step delay in OSC cycles (swing build only)
//   wr_en        pattern RAM write strobe
//   wr_addr      pattern RAM write address
//   wr_note      note number to write
//   wr_active    0 marks the written step as a rest
//   step         index of the current step
//   note         note latched at step start
//   gate         note gate
//   trigger      one-cycle pulse at the start of each active step
//   wrap         one-cycle pulse when the step index returns to 0
// -----------------------------------------------------------------------------
module step_sequencer #(
  parameter int STEPS     = 16,
  parameter int NOTE_BITS = 7,
  parameter int GATE_BITS = 24,
  localparam int SB       = $clog2(STEPS)
) (
  input  logic                 OSC,
  input  logic                 RESET,
  input  logic                 tick_in,
  input  logic                 run,
  input  logic [SB-1:0]        length,
  input  logic [GATE_BITS-1:0] gate_len,
`ifdef STEP_SEQUENCER_SWING_EN
  input  logic [GATE_BITS-1:0] swing_delay,
`endif
  input  logic                 wr_en,
  input  logic [SB-1:0]        wr_addr,
  input  logic [NOTE_BITS-1:0] wr_note,
  input  logic                 wr_active,
  output logic [SB-1:0]        step,
  output logic [NOTE_BITS-1:0] note,
  output logic                 gate,
  output logic                 trigger,
  output logic                 wrap
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_GATE  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
`ifdef STEP_SEQUENCER_SWING_EN
  localparam logic [2:0] S_DELAY = 3'd4;
`endif

  // ---------------------------------------------------------------------------
  // Tick conditioning: 2-flop synchronizer, then a registered rising-edge
  // detector. The registered detector output puts the FSM action at the third
  // edge after tick_in is first sampled high.
  // ---------------------------------------------------------------------------
  logic meta_q, sync_q, prev_q, tick_p_q;
  logic run_q;

  always_ff @(posedge OSC or negedge RESET) begin
    if (!RESET) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      prev_q   <= 1'b0;
      tick_p_q <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples the pre-edge value of its neighbours.
      meta_q   <= tick_in;
      sync_q   <= meta_q;
      prev_q   <= sync_q;
      tick_p_q <= sync_q & ~prev_q;
      run_q    <= run;
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern RAM: {active, note} per step.
  // ---------------------------------------------------------------------------
  logic [NOTE_BITS:0] ram_q [STEPS];

  // NOTE: the pattern RAM deliberately has no reset so it maps onto plain
  // memory and a pattern survives a reset.
  always_ff @(posedge OSC) begin
    if (wr_en) ram_q[wr_addr] <= {wr_active, wr_note};
  end

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  logic [2:0]           state_q,     state_d;
  logic [GATE_BITS-1:0] cnt_q,       cnt_d;
  logic [SB-1:0]        step_q,      step_d;
  logic [NOTE_BITS-1:0] note_q,      note_d;
  logic                 gate_q,      gate_d;
  logic                 trigger_q,   trigger_d;
  logic                 wrap_q,      wrap_d;
  logic                 started_q,   started_d;   // step 0 already played
  logic [SB-1:0]        pend_step_q, pend_step_d; // step held across GAP/DELAY
  logic                 pend_wrap_q, pend_wrap_d;

  logic                 tick_v;     // tick qualified by the raw run level
  logic                 deferred;   // tick held over from an aborted DELAY
  logic [SB-1:0]        nxt_idx;
  logic                 nxt_wrap;
  logic [SB-1:0]        sel_idx;
  logic                 sel_wrap;
  logic                 start;
  logic                 play;
  logic [NOTE_BITS:0]   rd_entry;

`ifdef STEP_SEQUENCER_SWING_EN
  logic hold_q, hold_d;
  assign deferred = hold_q;
`else
  assign deferred = 1'b0;
`endif

  // A tick coinciding with run falling is dropped: run wins.
  assign tick_v = tick_p_q & run;

  // Index for the next tick. The first tick after leaving IDLE plays step 0
  // without advancing; any step at or past length wraps.
  always_comb begin
    nxt_idx  = '0;
    nxt_wrap = 1'b0;
    if (started_q) begin
      if (step_q >= length) nxt_wrap = 1'b1;
      else                  nxt_idx  = SB'(step_q + 1'b1);
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    note_d      = note_q;
    gate_d      = gate_q;
    trigger_d   = 1'b0;
    wrap_d      = 1'b0;
    started_d   = started_q;
    pend_step_d = pend_step_q;
    pend_wrap_d = pend_wrap_q;
    sel_idx     = nxt_idx;
    sel_wrap    = nxt_wrap;
    start       = 1'b0;
    play        = 1'b0;
`ifdef STEP_SEQUENCER_SWING_EN
    hold_d      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        step_d    = '0;
        gate_d    = 1'b0;
        started_d = 1'b0;
        if (run_q) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tick_v || deferred) start = 1'b1;
      end
      S_GATE: begin
        if (deferred) begin
          start = 1'b1;
        end else if (tick_v) begin
          // Early tick: drop the gate for one cycle, play the step next cycle.
          gate_d      = 1'b0;
          pend_step_d = nxt_idx;
          pend_wrap_d = nxt_wrap;
          state_d     = S_GAP;
        end else if (cnt_q <= GATE_BITS'(1)) begin
          gate_d  = 1'b0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - GATE_BITS'(1);
        end
      end
      S_GAP: begin
        // A tick landing in this single cycle is dropped; ticks arrive at
        // least two cycles apart after edge detection.
        sel_idx  = pend_step_q;
        sel_wrap = pend_wrap_q;
        start    = 1'b1;
      end
`ifdef STEP_SEQUENCER_SWING_EN
      S_DELAY: begin
        sel_idx  = pend_step_q;
        sel_wrap = pend_wrap_q;
        if (tick_v) begin
          // New tick ends the delay; it is replayed next cycle.
          play   = 1'b1;
          hold_d = 1'b1;
        end else if (cnt_q <= GATE_BITS'(1)) begin
          play = 1'b1;
        end else begin
          cnt_d = cnt_q - GATE_BITS'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (start) begin
`ifdef STEP_SEQUENCER_SWING_EN
      if (sel_idx[0] && (swing_delay != '0)) begin
        state_d     = S_DELAY;
        cnt_d       = swing_delay;
        pend_step_d = sel_idx;
        pend_wrap_d = sel_wrap;
        gate_d      = 1'b0;
      end else begin
        play = 1'b1;
      end
`else
      play = 1'b1;
`endif
    end

    rd_entry = ram_q[sel_idx];

    if (play) begin
      step_d    = sel_idx;
      wrap_d    = sel_wrap;
      note_d    = rd_entry[NOTE_BITS-1:0];
      started_d = 1'b1;
      if (rd_entry[NOTE_BITS] && (gate_len != '0)) begin
        trigger_d = 1'b1;
        gate_d    = 1'b1;
        cnt_d     = gate_len;
        state_d   = S_GATE;
      end else begin
        gate_d  = 1'b0;
        state_d = S_WAIT;
      end
    end

    // run low overrides everything, one edge after it is registered.
    if (!run_q) begin
      state_d   = S_IDLE;
      step_d    = '0;
      gate_d    = 1'b0;
      trigger_d = 1'b0;
      wrap_d    = 1'b0;
      started_d = 1'b0;
`ifdef STEP_SEQUENCER_SWING_EN
      hold_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge OSC or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      step_q      <= '0;
      note_q      <= '0;
      gate_q      <= 1'b0;
      trigger_q   <= 1'b0;
      wrap_q      <= 1'b0;
      started_q   <= 1'b0;
      pend_step_q <= '0;
      pend_wrap_q <= 1'b0;
`ifdef STEP_SEQUENCER_SWING_EN
      hold_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      note_q      <= note_d;
      gate_q      <= gate_d;
      trigger_q   <= trigger_d;
      wrap_q      <= wrap_d;
      started_q   <= started_d;
      pend_step_q <= pend_step_d;
      pend_wrap_q <= pend_wrap_d;
`ifdef STEP_SEQUENCER_SWING_EN
      hold_q      <= hold_d;
`endif
    end
  end

  assign step    = step_q;
  assign note    = note_q;
  assign gate    = gate_q;
  assign trigger = trigger_q;
  assign wrap    = wrap_q;

endmodule
